// File: rtl/gcd_arbiter.sv
// Round-robin scheduler sharing one gcd engine between NREQ requesters; zero operands bypass the engine.
// Latency accept->resp: 1 cycle for a zero bypass, 4+S for an engine job; no response backpressure.
module gcd_arbiter #(
    parameter int GCDw = 32,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*GCDw-1:0] req_in1,
    input  logic [NREQ*GCDw-1:0] req_in2,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [GCDw-1:0]      resp_gcd,
    output logic                 busy,
    output logic                 eng_enable,
    output logic [GCDw-1:0]      eng_in1,
    output logic [GCDw-1:0]      eng_in2,
    input  logic                 eng_done,
    input  logic [GCDw-1:0]      eng_gcd
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0] NREQ_W = NREQ[PW:0];
    localparam logic [PW:0] ONE_W  = {{PW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, START, BUSY, HOLD, RESP} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, gid, win, off, ptr_nx;
    logic [PW:0]     sum, win_inc;
    logic [NREQ-1:0] rot;
    logic            any, bypass;
    logic [GCDw-1:0] op_a, op_b, result;

    // Rotate the request vector so bit 0 is the requester at ptr, then pick the lowest set bit.
    always_comb begin
        rot = NREQ'({req_valid, req_valid} >> ptr);
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) off = PW'(k);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        win = sum[PW-1:0];

        win_inc = {1'b0, win} + ONE_W;
        ptr_nx  = (win_inc == NREQ_W) ? '0 : win_inc[PW-1:0];

        op_a = '0;
        op_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win == PW'(k)) begin
                op_a = req_in1[k*GCDw +: GCDw];
                op_b = req_in2[k*GCDw +: GCDw];
            end
        end
        any    = |req_valid;
        bypass = (op_a == '0) || (op_b == '0);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any) state_nx = bypass ? RESP : START;
            START:   state_nx = BUSY;
            BUSY:    if (eng_done) state_nx = HOLD;
            HOLD:    state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_gcd   = '0;
        if (state == IDLE && any) req_ready[win] = 1'b1;
        if (state == RESP) begin
            resp_valid[gid] = 1'b1;
            resp_gcd        = result;
        end
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            gid        <= '0;
            result     <= '0;
            eng_enable <= 1'b0;
            eng_in1    <= '0;
            eng_in2    <= '0;
        end else begin
            state      <= state_nx;
            eng_enable <= (state_nx == START) || (state_nx == BUSY) || (state_nx == HOLD);
            case (state)
                IDLE: begin
                    if (any) begin
                        gid <= win;
                        ptr <= ptr_nx;
                        if (bypass) begin
                            // gcd(a,0)=a, gcd(0,b)=b, gcd(0,0)=0 all collapse to a|b.
                            result <= op_a | op_b;
                        end else begin
                            eng_in1 <= op_a;
                            eng_in2 <= op_b;
                        end
                    end
                end
                HOLD:    result <= eng_gcd;
                default: ;
            endcase
        end
    end

endmodule
